// File: rtl/regfile_access_seq.sv
`timescale 1ns/1ps
// Purpose : operand-fetch sequencer between decode and the register file, with a
//           one-entry write scoreboard that stalls RAW/WAW requests until writeback.
// Latency : request accepted in cycle A -> regfile read in A+1, opr_valid in A+3.
// Backpr. : req_ready low outside IDLE or on hazard; operands held while opr_ready=0;
//           writebacks always accepted (wb_ready=1 out of reset).
//
// Ports:
//   hclk, hrstn                      clock, async active-low reset
//   req_valid/req_ready, req_*       operand-fetch request (indices, use flags, rd_wen)
//   reg_raddr_x/reg_ren_x            regfile read ports (data returns one cycle later
//   reg_rdata_x                      on reg_rdata_x)
//   reg_waddr/reg_wdata/reg_wen      regfile write port
//   opr_valid/opr_ready, opr_*       fetched operands and destination to execute
//   wb_valid/wb_ready, wb_rd/wb_data writeback from execute
//   busy                             fetch in progress or write outstanding
module regfile_access_seq (
  input  logic        hclk,
  input  logic        hrstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [4:0]  req_rd,
  input  logic        req_use_rs1,
  input  logic        req_use_rs2,
  input  logic        req_rd_wen,
  output logic [4:0]  reg_raddr_1,
  output logic [4:0]  reg_raddr_2,
  output logic        reg_ren_1,
  output logic        reg_ren_2,
  input  logic [31:0] reg_rdata_1,
  input  logic [31:0] reg_rdata_2,
  output logic [4:0]  reg_waddr,
  output logic [31:0] reg_wdata,
  output logic        reg_wen,
  output logic        opr_valid,
  input  logic        opr_ready,
  output logic [31:0] opr_rs1_data,
  output logic [31:0] opr_rs2_data,
  output logic [4:0]  opr_rd,
  output logic        opr_rd_wen,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_CAPT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Latched request fields used after the READ cycle
  logic        r_use_rs1;
  logic        r_use_rs2;
  logic [4:0]  r_rd;
  logic        r_rd_wen;

  // Read-port drive registers; only non-zero during the single READ cycle
  logic        r_ren_1;
  logic        r_ren_2;
  logic [4:0]  r_raddr_1;
  logic [4:0]  r_raddr_2;

  logic [31:0] r_opr_rs1_data;
  logic [31:0] r_opr_rs2_data;
  logic [4:0]  r_opr_rd;
  logic        r_opr_rd_wen;

  logic        r_pend;
  logic [4:0]  r_pend_rd;

  logic        r_wen;
  logic [4:0]  r_waddr;
  logic [31:0] r_wdata;

  logic        w_hazard;
  logic        w_req_fire;
  logic        w_opr_fire;
  logic        w_wb_fire;
  logic        w_pend_set;
  logic        w_pend_clr;

  // Any source matching the outstanding write, or any new write while one is
  // outstanding (single-entry scoreboard), must wait for the writeback.
  assign w_hazard = r_pend && ((req_use_rs1 && (req_rs1 == r_pend_rd)) ||
                               (req_use_rs2 && (req_rs2 == r_pend_rd)) ||
                               req_rd_wen);

  // hrstn gates the ready outputs directly so nothing is accepted during reset
  // and a request is accepted in the very cycle reset is released.
  assign req_ready  = hrstn && (r_state == S_IDLE) && !w_hazard;
  assign wb_ready   = hrstn;

  assign w_req_fire = req_valid && req_ready;
  assign opr_valid  = (r_state == S_HOLD);
  assign w_opr_fire = opr_valid && opr_ready;
  assign w_wb_fire  = wb_valid && wb_ready;

  // x0 is never tracked, so a writeback to x0 can never clear a pend entry
  assign w_pend_set = w_opr_fire && r_opr_rd_wen && (r_opr_rd != 5'd0);
  assign w_pend_clr = w_wb_fire && r_pend && (wb_rd == r_pend_rd);

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_req_fire) w_state_nxt = S_READ;
      S_READ: w_state_nxt = S_CAPT;
      S_CAPT: w_state_nxt = S_HOLD;
      S_HOLD: if (w_opr_fire) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch and read-port drive; ren/raddr are loaded on accept and
  // return to zero on the following edge, so they are live only in READ.
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      r_use_rs1 <= 1'b0;
      r_use_rs2 <= 1'b0;
      r_rd      <= 5'd0;
      r_rd_wen  <= 1'b0;
      r_ren_1   <= 1'b0;
      r_ren_2   <= 1'b0;
      r_raddr_1 <= 5'd0;
      r_raddr_2 <= 5'd0;
    end else begin
      r_ren_1   <= w_req_fire && req_use_rs1;
      r_ren_2   <= w_req_fire && req_use_rs2;
      r_raddr_1 <= w_req_fire ? req_rs1 : 5'd0;
      r_raddr_2 <= w_req_fire ? req_rs2 : 5'd0;
      if (w_req_fire) begin
        r_use_rs1 <= req_use_rs1;
        r_use_rs2 <= req_use_rs2;
        r_rd      <= req_rd;
        r_rd_wen  <= req_rd_wen;
      end
    end
  end

  // Operand capture; payload is only reloaded in CAPT so it is stable in HOLD
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      r_opr_rs1_data <= 32'd0;
      r_opr_rs2_data <= 32'd0;
      r_opr_rd       <= 5'd0;
      r_opr_rd_wen   <= 1'b0;
    end else if (r_state == S_CAPT) begin
      r_opr_rs1_data <= r_use_rs1 ? reg_rdata_1 : 32'd0;
      r_opr_rs2_data <= r_use_rs2 ? reg_rdata_2 : 32'd0;
      r_opr_rd       <= r_rd;
      r_opr_rd_wen   <= r_rd_wen;
    end
  end

  // Scoreboard: set has priority so a new rd issued in the clearing cycle is kept
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      r_pend    <= 1'b0;
      r_pend_rd <= 5'd0;
    end else if (w_pend_set) begin
      r_pend    <= 1'b1;
      r_pend_rd <= r_opr_rd;
    end else if (w_pend_clr) begin
      r_pend    <= 1'b0;
    end
  end

  // Regfile write port: one pulse per accepted non-x0 writeback
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      r_wen   <= 1'b0;
      r_waddr <= 5'd0;
      r_wdata <= 32'd0;
    end else if (w_wb_fire && (wb_rd != 5'd0)) begin
      r_wen   <= 1'b1;
      r_waddr <= wb_rd;
      r_wdata <= wb_data;
    end else begin
      r_wen   <= 1'b0;
      r_waddr <= 5'd0;
      r_wdata <= 32'd0;
    end
  end

  assign reg_ren_1    = r_ren_1;
  assign reg_ren_2    = r_ren_2;
  assign reg_raddr_1  = r_raddr_1;
  assign reg_raddr_2  = r_raddr_2;
  assign reg_wen      = r_wen;
  assign reg_waddr    = r_waddr;
  assign reg_wdata    = r_wdata;
  assign opr_rs1_data = r_opr_rs1_data;
  assign opr_rs2_data = r_opr_rs2_data;
  assign opr_rd       = r_opr_rd;
  assign opr_rd_wen   = r_opr_rd_wen;
  assign busy         = (r_state != S_IDLE) || r_pend;

endmodule

// File: doc/regfile_access_seq.md
REGFILE_ACCESS_SEQ -- requirements
Module: regfile_access_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed: 5-bit register index, 32-bit data.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, as listed below.
REQ-003 hclk  in  1  clock; all state changes on rising edge.
REQ-004 hrstn  in  1  asynchronous active-low reset.
REQ-005 req_valid/req_ready  in/out  1/1  operand-fetch request handshake.
REQ-006 req_rs1, req_rs2, req_rd  in  5 each  source and destination indices.
REQ-007 req_use_rs1, req_use_rs2, req_rd_wen  in  1 each  operand-used flags and destination-write flag.
REQ-008 reg_raddr_1, reg_raddr_2  out  5 each  regfile read addresses.
REQ-009 reg_ren_1, reg_ren_2  out  1 each  regfile read enables.
REQ-010 reg_rdata_1, reg_rdata_2  in  32 each  regfile read data, valid one cycle after the enable.
REQ-011 reg_waddr/reg_wdata/reg_wen  out  5/32/1  regfile write port.
REQ-012 opr_valid/opr_ready  out/in  1/1  operand handshake to execute.
REQ-013 opr_rs1_data, opr_rs2_data  out  32 each  fetched operands.
REQ-014 opr_rd/opr_rd_wen  out  5/1  destination passed through.
REQ-015 wb_valid/wb_ready  in/out  1/1  writeback handshake; wb_rd in 5, wb_data in 32.
REQ-016 busy  out  1  high when state != IDLE or a write is pending.

Function
REQ-017 The FSM SHALL have states IDLE, READ, CAPT and HOLD.
REQ-018 IDLE -> READ on req_valid && req_ready; the block latches rs1, rs2, rd, the use flags and rd_wen.
REQ-019 In READ, for exactly one cycle, the block SHALL drive reg_ren_x = latched use_rsx and reg_raddr_x = latched rsx, from registers; READ -> CAPT.
REQ-020 In CAPT, the block SHALL capture reg_rdata_x into opr_rsx_data, or 0 when use_rsx = 0; CAPT -> HOLD.
REQ-021 In HOLD, opr_valid SHALL be 1 with stable payload; HOLD -> IDLE on opr_valid && opr_ready.
REQ-022 Latency SHALL be as follows: request accepted in cycle A gives opr_valid first high in cycle A+3, and req_ready can be high again in the cycle after the operand handshake.
REQ-023 Outside READ, reg_ren_x SHALL be 0 and reg_raddr_x SHALL be 0.
REQ-024 The scoreboard SHALL hold one outstanding write: pend (1 bit) and pend_rd (5 bits).
  - Set on the operand handshake when opr_rd_wen = 1 and opr_rd != 0.
REQ-025 A writeback accepted with wb_rd == pend_rd SHALL clear pend.
  - On a simultaneous set and clear in the same cycle, set wins and pend_rd takes the new rd.
REQ-026 req_ready SHALL be 1 only in IDLE, and only when none of the following holds:
  - pend && req_use_rs1 && req_rs1 == pend_rd;
  - pend && req_use_rs2 && req_rs2 == pend_rd;
  - pend && req_rd_wen.
  req_ready may depend combinationally on the request payload.
REQ-027 wb_ready SHALL be 1 whenever out of reset.
REQ-028 An accepted writeback SHALL drive reg_wen = 1, reg_waddr = wb_rd and reg_wdata = wb_data in the next cycle only.
  - If wb_rd = 0, the writeback is accepted but reg_wen stays 0.
REQ-029 A read issued in the same cycle as reg_wen to the same address SHALL rely on the regfile's write-to-read bypass; the block adds no forwarding of its own.
REQ-030 Back-to-back writebacks SHALL produce back-to-back reg_wen pulses, one per accepted writeback.

Reset
REQ-031 While hrstn = 0, the block SHALL hold:
  - state IDLE, pend = 0;
  - req_ready = 0 and wb_ready = 0;
  - every registered output at 0 (opr_*, reg_*, busy).
REQ-032 On reset mid-operation, the block SHALL abandon any in-flight fetch and any queued write; there is no replay after reset.
REQ-033 The first request SHALL be acceptable in the first cycle after hrstn rises.

Verification
REQ-034 Basic fetch: regfile x5 = 0x11, x6 = 0x22; request rs1 = 5, rs2 = 6 in cycle A -> reg_ren_1/2 high in A+1, opr_valid in A+3 with data 0x11/0x22.
REQ-035 Unused operand: use_rs2 = 0, rs2 = 7 -> reg_ren_2 stays 0 and opr_rs2_data = 0.
REQ-036 RAW hazard: issue rd = 3 with rd_wen = 1, then request rs1 = 3 -> req_ready = 0 until wb_rd = 3, wb_data = 0xABCD is accepted; the fetch then returns 0xABCD via bypass.
REQ-037 x0 writeback: wb_rd = 0, wb_data = 0xFFFF -> reg_wen never asserts and pend is unaffected.
REQ-038 Backpressure: hold opr_ready = 0 for 5 cycles -> opr_valid and payload stay stable, req_ready = 0, and busy = 1.
REQ-039 Reset in CAPT: hrstn pulsed low -> all outputs 0 immediately; after release, a new request completes normally in 3 cycles.
